// File: rtl/acc_load_unpacker_if.sv
// ============================================================================
// Module      : acc_load_unpacker_if
// Description : Bus bundle for acc_load_unpacker. Carries the APB write
//               signals, the register/status outputs and the byte-stream
//               handshake towards the conv core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface acc_load_unpacker_if;
  // APB side
  logic [12:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic        PREADY;
  logic        PSLVERR;
  // Register / status side
  logic        acc_en;
  logic        a_loaded;
  logic        x_loaded;
  // Byte stream towards the conv core
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_is_a;
  logic        out_last;

  // Seen from the unpacker
  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE, out_ready,
    output PREADY, PSLVERR, acc_en, a_loaded, x_loaded,
           out_valid, out_data, out_is_a, out_last
  );

  // Seen from the APB master / conv core side
  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE, out_ready,
    input  PREADY, PSLVERR, acc_en, a_loaded, x_loaded,
           out_valid, out_data, out_is_a, out_last
  );
endinterface

`default_nettype wire

// File: rtl/acc_load_unpacker.sv
// ============================================================================
// Module      : acc_load_unpacker
// Description : APB load front end of the convolution accelerator. Decodes
//               the enable and matrix-load writes, buffers 32-bit load words
//               in a small FIFO and unpacks them into a byte stream with a
//               valid/ready handshake (filter A and input X, row-major).
//               Optional macro ACC_LOAD_OVF_ERR_EN: raise PSLVERR on load
//               writes that are dropped (disabled or matrix already full).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_load_unpacker #(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          A_BYTES     = 9,
  parameter int          X_BYTES     = 784,
  parameter logic [12:0] EN_ADDR     = 13'h1FFF,
  parameter logic [12:0] LOAD_A_ADDR = 13'd1,
  parameter logic [12:0] LOAD_X_ADDR = 13'd2
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  acc_load_unpacker_if.slave   bus
);

  localparam int A_WORDS = (A_BYTES + 3) / 4;
  localparam int X_WORDS = (X_BYTES + 3) / 4;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int MAXW    = (A_WORDS > X_WORDS) ? A_WORDS : X_WORDS;
  localparam int MAXB    = (A_BYTES > X_BYTES) ? A_BYTES : X_BYTES;
  localparam int WCW     = $clog2(MAXW + 1);
  localparam int BCW     = $clog2(MAXB + 1);
  localparam int EW      = 1 + 3 + 32;   // {kind, lanes, aligned data}

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic          r_acc_en;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [WCW-1:0] r_a_words;
  logic [WCW-1:0] r_x_words;
  logic [BCW-1:0] r_a_bytes;
  logic [BCW-1:0] r_x_bytes;
  logic          r_a_loaded;
  logic          r_x_loaded;
  state_t        r_state;
  logic          r_valid;
  logic [7:0]    r_data;
  logic          r_is_a;
  logic          r_last;
  logic [31:0]   r_shift;
  logic [2:0]    r_lanes;

  // --------------------------------------------------------------------------
  // APB decode
  // --------------------------------------------------------------------------
  logic        w_full;
  logic        w_empty;
  logic        w_is_load_a;
  logic        w_is_load_x;
  logic        w_is_load;
  logic        w_pready;
  logic        w_wr;
  logic        w_en_wr;
  logic        w_flush;
  logic        w_kind_done;
  logic        w_push;

  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  assign w_is_load_a = (bus.PADDR == LOAD_A_ADDR);
  assign w_is_load_x = (bus.PADDR == LOAD_X_ADDR);
  assign w_is_load   = w_is_load_a | w_is_load_x;

  // Only a load write into a full FIFO is stalled; everything else is zero-wait
  assign w_pready = !(bus.PSEL && bus.PWRITE && w_is_load && w_full);
  assign w_wr     = bus.PSEL && bus.PENABLE && bus.PWRITE && w_pready;
  assign w_en_wr  = w_wr && (bus.PADDR == EN_ADDR);
  assign w_flush  = w_en_wr && !bus.PWDATA[0];

  assign w_kind_done = w_is_load_a ? (r_a_words == WCW'(A_WORDS))
                                   : (r_x_words == WCW'(X_WORDS));
  assign w_push      = w_wr && w_is_load && r_acc_en && !w_kind_done && !w_full;

`ifdef ACC_LOAD_OVF_ERR_EN
  assign bus.PSLVERR = bus.PSEL && bus.PENABLE && bus.PWRITE && w_is_load &&
                       (!r_acc_en || w_kind_done);
`else
  assign bus.PSLVERR = 1'b0;
`endif

  assign bus.PREADY = w_pready;

  // --------------------------------------------------------------------------
  // Lane count and alignment of the word being pushed. A short final word
  // carries its r valid bytes in the low lanes; shifting them to the top lets
  // the unpacker always emit from [31:24] downwards.
  // --------------------------------------------------------------------------
  logic [31:0] w_rem;
  logic [2:0]  w_lanes;
  logic [31:0] w_aligned;

  assign w_rem   = w_is_load_a ? (32'(A_BYTES) - (32'(r_a_words) << 2))
                               : (32'(X_BYTES) - (32'(r_x_words) << 2));
  assign w_lanes = (w_rem >= 32'd4) ? 3'd4 : w_rem[2:0];

  // Left-justify the valid lanes of the incoming word
  always_comb begin
    w_aligned = bus.PWDATA;
    case (w_lanes)
      3'd1:    w_aligned = {bus.PWDATA[7:0],  24'h0};
      3'd2:    w_aligned = {bus.PWDATA[15:0], 16'h0};
      3'd3:    w_aligned = {bus.PWDATA[23:0], 8'h0};
      default: w_aligned = bus.PWDATA;
    endcase
  end

  // --------------------------------------------------------------------------
  // Unpacker control
  // --------------------------------------------------------------------------
  logic [EW-1:0]  w_head;
  logic           w_head_kind;
  logic [2:0]     w_head_lanes;
  logic [31:0]    w_head_data;
  logic           w_hs;
  logic           w_pop;
  logic [BCW-1:0] w_a_bytes_nxt;
  logic [BCW-1:0] w_x_bytes_nxt;
  logic           w_next_kind;
  logic           w_next_last;

  assign w_head       = r_mem[r_rptr[AW-1:0]];
  assign w_head_kind  = w_head[EW-1];
  assign w_head_lanes = w_head[EW-2 -: 3];
  assign w_head_data  = w_head[31:0];

  assign w_hs  = r_valid && bus.out_ready;
  // Pop in IDLE, or on the final-lane handshake so the next word follows with no bubble
  assign w_pop = !w_flush && !w_empty &&
                 ((r_state == S_IDLE) || (w_hs && (r_lanes == 3'd1)));

  // Byte counts after this cycle's handshake decide whether the next byte shown is the last
  assign w_a_bytes_nxt = r_a_bytes + BCW'(w_hs && r_is_a);
  assign w_x_bytes_nxt = r_x_bytes + BCW'(w_hs && !r_is_a);
  assign w_next_kind   = w_pop ? w_head_kind : r_is_a;
  assign w_next_last   = w_next_kind ? (w_a_bytes_nxt == BCW'(A_BYTES - 1))
                                     : (w_x_bytes_nxt == BCW'(X_BYTES - 1));

  // Enable register; a write of 0 also triggers the flush
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_acc_en <= 1'b0;
    end else if (w_en_wr) begin
      r_acc_en <= bus.PWDATA[0];
    end
  end

  // FIFO pointers; push is gated by the full flag seen this cycle
  always_ff @(posedge HCLK) begin
    if (!HRESETn || w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge HCLK) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {w_is_load_a, w_lanes, w_aligned};
    end
  end

  // Per-kind word counters, advanced at push
  always_ff @(posedge HCLK) begin
    if (!HRESETn || w_flush) begin
      r_a_words <= '0;
      r_x_words <= '0;
    end else if (w_push) begin
      if (w_is_load_a) r_a_words <= r_a_words + WCW'(1);
      else             r_x_words <= r_x_words + WCW'(1);
    end
  end

  // Per-kind byte counters and matrix-complete flags, advanced on handshake
  always_ff @(posedge HCLK) begin
    if (!HRESETn || w_flush) begin
      r_a_bytes  <= '0;
      r_x_bytes  <= '0;
      r_a_loaded <= 1'b0;
      r_x_loaded <= 1'b0;
    end else if (w_hs) begin
      r_a_bytes <= w_a_bytes_nxt;
      r_x_bytes <= w_x_bytes_nxt;
      if (r_last && r_is_a)  r_a_loaded <= 1'b1;
      if (r_last && !r_is_a) r_x_loaded <= 1'b1;
    end
  end

  // Unpacker FSM with registered byte-stream outputs
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_is_a  <= 1'b0;
      r_last  <= 1'b0;
      r_shift <= 32'h0;
      r_lanes <= 3'd0;
    end else if (w_flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_lanes <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_data  <= w_head_data[31:24];
            r_shift <= {w_head_data[23:0], 8'h00};
            r_lanes <= w_head_lanes;
            r_is_a  <= w_head_kind;
            r_last  <= w_next_last;
            r_valid <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_hs) begin
            if (r_lanes != 3'd1) begin
              r_data  <= r_shift[31:24];
              r_shift <= {r_shift[23:0], 8'h00};
              r_lanes <= r_lanes - 3'd1;
              r_last  <= w_next_last;
            end else if (w_pop) begin
              r_data  <= w_head_data[31:24];
              r_shift <= {w_head_data[23:0], 8'h00};
              r_lanes <= w_head_lanes;
              r_is_a  <= w_head_kind;
              r_last  <= w_next_last;
            end else begin
              r_valid <= 1'b0;
              r_lanes <= 3'd0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc_en    = r_acc_en;
  assign bus.a_loaded  = r_a_loaded;
  assign bus.x_loaded  = r_x_loaded;
  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.out_is_a  = r_is_a;
  assign bus.out_last  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_acc_load_unpacker.sv
// ============================================================================
// Module      : tb_acc_load_unpacker
// Description : Self-checking bench for acc_load_unpacker. Expected bytes are
//               queued when a load write is accepted and compared by a
//               separate monitor on every out_valid & out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_load_unpacker;

  localparam int          A_BYTES = 9;
  localparam int          X_BYTES = 784;
  localparam int          A_WORDS = (A_BYTES + 3) / 4;
  localparam int          X_WORDS = (X_BYTES + 3) / 4;
  localparam logic [12:0] EN_ADDR = 13'h1FFF;
  localparam logic [12:0] LA_ADDR = 13'd1;
  localparam logic [12:0] LX_ADDR = 13'd2;

  typedef struct packed {
    logic       is_a;
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESETn;
  acc_load_unpacker_if bus ();

  acc_load_unpacker dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  // Reference model state
  bit m_en;
  int m_a_words;
  int m_x_words;

  // Monitor bookkeeping
  int mon_x_cnt = 0;
  bit bubble_watch = 0;
  bit seen_first = 0;
  int bubbles = 0;
  bit prev_stall = 0;
  logic [9:0] prev_word;

  // Ready generation
  bit   rand_mode = 0;
  logic tb_ready = 1'b1;
  logic rnd_ready = 1'b1;
  assign bus.out_ready = rand_mode ? rnd_ready : tb_ready;

  always @(posedge HCLK) begin
    #1 rnd_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte sequence of one matrix word derived from its position in the matrix
  function automatic void model_load(input bit is_a, input logic [31:0] w);
    int total, cnt, n, idx;
    logic [31:0] wv;
    exp_t e;
    wv    = w;
    total = is_a ? A_BYTES : X_BYTES;
    cnt   = is_a ? m_a_words : m_x_words;
    n     = total - 4 * cnt;
    if (n > 4) n = 4;
    for (int i = 0; i < n; i++) begin
      idx    = 4 * cnt + i;
      e.is_a = is_a;
      e.data = wv[8 * (n - 1 - i) +: 8];
      e.last = (idx == total - 1);
      exp_q.push_back(e);
    end
    if (is_a) m_a_words++;
    else      m_x_words++;
  endfunction

  function automatic void model_flush();
    exp_q.delete();
    m_a_words = 0;
    m_x_words = 0;
  endfunction

  // One APB write; returns the number of wait states seen
  task automatic apb_write(input logic [12:0] addr, input logic [31:0] data, output int waits);
    logic rdy, err;
    bit   is_a, exp_err;
    int   cnt, words;
    rdy = 1'b0;
    err = 1'b0;
    @(posedge HCLK);
    #1;
    bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = addr; bus.PWDATA = data; bus.PENABLE = 1'b0;
    @(posedge HCLK);
    #1 bus.PENABLE = 1'b1;
    waits = 0;
    forever begin
      @(negedge HCLK);
      rdy = bus.PREADY;
      err = bus.PSLVERR;
      @(posedge HCLK);
      if (rdy) break;
      waits++;
      if (waits > 400) begin
        chk("pready_timeout", 32'(rdy), 32'd1);
        break;
      end
    end
    if (addr == EN_ADDR) begin
      m_en = data[0];
      if (!data[0]) model_flush();
    end else if (addr == LA_ADDR || addr == LX_ADDR) begin
      is_a  = (addr == LA_ADDR);
      cnt   = is_a ? m_a_words : m_x_words;
      words = is_a ? A_WORDS : X_WORDS;
`ifdef ACC_LOAD_OVF_ERR_EN
      exp_err = !m_en || (cnt >= words);
`else
      exp_err = 1'b0;
`endif
      chk("pslverr", 32'(err), 32'(exp_err));
      if (m_en && cnt < words) model_load(is_a, data);
    end
    #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 6000) begin
      @(posedge HCLK);
      n++;
    end
    repeat (2) @(posedge HCLK);
    #1 chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor
  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESETn) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && bus.out_valid)
        chk("stable_under_stall", {22'h0, bus.out_is_a, bus.out_data, bus.out_last},
            {22'h0, prev_word});
      if (bubble_watch && seen_first && !bus.out_valid) bubbles++;
      if (bubble_watch && bus.out_valid) seen_first = 1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: actual=%0h expected=none at %0t", bus.out_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {22'h0, bus.out_is_a, bus.out_data, bus.out_last},
              {22'h0, e.is_a, e.data, e.last});
          if (!e.is_a) mon_x_cnt++;
          if (!e.is_a && e.last) bubble_watch = 0;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_word  = {bus.out_is_a, bus.out_data, bus.out_last};
    end
  end

  initial begin
    int w, base, n, apos;
    logic [31:0] d;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    m_en = 0; m_a_words = 0; m_x_words = 0;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_pready",   32'(bus.PREADY),    32'd1);
    chk("rst_pslverr",  32'(bus.PSLVERR),   32'd0);
    chk("rst_acc_en",   32'(bus.acc_en),    32'd0);
    chk("rst_valid",    32'(bus.out_valid), 32'd0);
    chk("rst_data",     32'(bus.out_data),  32'd0);
    chk("rst_is_a",     32'(bus.out_is_a),  32'd0);
    chk("rst_last",     32'(bus.out_last),  32'd0);
    chk("rst_a_loaded", 32'(bus.a_loaded),  32'd0);
    chk("rst_x_loaded", 32'(bus.x_loaded),  32'd0);

    // Load while disabled is dropped
    apb_write(LA_ADDR, 32'hDEADBEEF, w);
    repeat (4) @(posedge HCLK);
    #1 chk("drop_disabled_valid", 32'(bus.out_valid), 32'd0);

    apb_write(EN_ADDR, 32'h1, w);
    chk("acc_en_set", 32'(bus.acc_en), 32'd1);

    // Filter load, last word partial with one byte in [7:0]
    apb_write(LA_ADDR, 32'h01020304, w);
    apb_write(LA_ADDR, 32'h05060708, w);
    apb_write(LA_ADDR, 32'h00000009, w);
    drain("a_drain");
    chk("a_loaded", 32'(bus.a_loaded), 32'd1);
    chk("x_loaded_low", 32'(bus.x_loaded), 32'd0);

    // Extra A word after completion is dropped
    apb_write(LA_ADDR, 32'h0A0B0C0D, w);
    repeat (4) @(posedge HCLK);
    #1 chk("a_overflow_valid", 32'(bus.out_valid), 32'd0);

    // Full X stream with incrementing bytes, no bubbles allowed
    seen_first = 0; bubbles = 0; bubble_watch = 1;
    for (int k = 0; k < X_WORDS; k++) begin
      for (int i = 0; i < 4; i++) d[31 - 8 * i -: 8] = 8'((4 * k + i) % 16);
      apb_write(LX_ADDR, d, w);
    end
    drain("x_drain");
    chk("x_bubbles", 32'(bubbles), 32'd0);
    chk("x_loaded", 32'(bus.x_loaded), 32'd1);
    bubble_watch = 0;

    apb_write(EN_ADDR, 32'h0, w);
    chk("acc_en_clear", 32'(bus.acc_en), 32'd0);
    chk("a_loaded_clear", 32'(bus.a_loaded), 32'd0);
    chk("x_loaded_clear", 32'(bus.x_loaded), 32'd0);
    apb_write(EN_ADDR, 32'h1, w);

    // Backpressure: FIFO plus the word held in the unpacker absorb five writes
    tb_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      apb_write(LX_ADDR, $urandom, w);
      chk("no_stall", 32'(w), 32'd0);
    end
    fork
      begin
        apb_write(LX_ADDR, $urandom, n);
      end
      begin
        repeat (8) @(posedge HCLK);
        @(negedge HCLK);
        chk("pready_full", 32'(bus.PREADY), 32'd0);
        tb_ready = 1'b1;
      end
    join
    chk("stall_seen", 32'(n > 0), 32'd1);
    drain("bp_drain");

    // Flush in the middle of an X stream
    apb_write(EN_ADDR, 32'h0, w);
    apb_write(EN_ADDR, 32'h1, w);
    base = mon_x_cnt;
    rand_mode = 1;
    for (int k = 0; k < 30; k++) apb_write(LX_ADDR, $urandom, w);
    rand_mode = 0;
    tb_ready = 1'b1;
    n = 0;
    while ((mon_x_cnt - base) < 100 && n < 500) begin
      @(posedge HCLK);
      n++;
    end
    chk("flush_progress", 32'((mon_x_cnt - base) >= 100), 32'd1);
    apb_write(EN_ADDR, 32'h0, w);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_x_loaded", 32'(bus.x_loaded), 32'd0);

    // Full reload with interleaved A words and random ready
    apb_write(EN_ADDR, 32'h1, w);
    rand_mode = 1;
    apos = 0;
    for (int k = 0; k < X_WORDS; k++) begin
      if (apos < A_WORDS && (k % 50) == 7) begin
        apb_write(LA_ADDR, $urandom, w);
        apos++;
      end
      apb_write(LX_ADDR, $urandom, w);
    end
    while (apos < A_WORDS) begin
      apb_write(LA_ADDR, $urandom, w);
      apos++;
    end
    drain("reload_drain");
    rand_mode = 0;
    chk("reload_a_loaded", 32'(bus.a_loaded), 32'd1);
    chk("reload_x_loaded", 32'(bus.x_loaded), 32'd1);

    // Reset while bytes are being held in SHIFT
    apb_write(EN_ADDR, 32'h0, w);
    apb_write(EN_ADDR, 32'h1, w);
    tb_ready = 1'b0;
    apb_write(LA_ADDR, 32'h11223344, w);
    apb_write(LA_ADDR, 32'h55667788, w);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge HCLK);
      n++;
    end
    @(posedge HCLK);
    #1 HRESETn = 1'b0;
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    m_en = 0;
    model_flush();
    chk("mid_rst_valid",    32'(bus.out_valid), 32'd0);
    chk("mid_rst_data",     32'(bus.out_data),  32'd0);
    chk("mid_rst_is_a",     32'(bus.out_is_a),  32'd0);
    chk("mid_rst_last",     32'(bus.out_last),  32'd0);
    chk("mid_rst_acc_en",   32'(bus.acc_en),    32'd0);
    chk("mid_rst_pready",   32'(bus.PREADY),    32'd1);
    chk("mid_rst_a_loaded", 32'(bus.a_loaded),  32'd0);
    tb_ready = 1'b1;
    repeat (6) @(posedge HCLK);
    #1 chk("mid_rst_fifo_empty", 32'(bus.out_valid), 32'd0);
    apb_write(EN_ADDR, 32'h1, w);
    for (int k = 0; k < A_WORDS; k++) apb_write(LA_ADDR, $urandom, w);
    drain("post_rst_drain");
    chk("post_rst_a_loaded", 32'(bus.a_loaded), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
